// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Serializes the PCI host path, the user/compute path and the completion-flag
// writer onto one board memory port, and routes read data back to its owner.
//
// Optional feature: define MEM_ARB_TIMEOUT_EN to add a read-wait watchdog.
// When it fires, the read returns 32'hDEAD_BEEF and rd_err pulses alongside
// rvalid. Without the macro, a read waits indefinitely and rd_err is tied 0.
//
// Handshake: a requester raises req with wr/addr/wdata and holds all of them
// stable until it sees its one-cycle gnt pulse (flag_ack for the flag writer).
// Requests are only looked at while the FSM is in IDLE. Memory reads use
// mem_rd_req held high until the first cycle mem_rd_ready is seen. The data
// is taken on that edge, and mem_rd_ready is ignored at any other time.
// Read data is handed back with a one-cycle rvalid pulse on the owning path.

module mem_port_arbiter #(
    parameter int                ADDR_W    = 21,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] FLAG_ADDR = 21'h07FFFE,
    parameter int                MAX_BURST = 16,
    parameter int                TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              h_req,
    input  logic              h_wr,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    output logic              h_gnt,
    output logic              h_rvalid,
    output logic [DATA_W-1:0] h_rdata,

    input  logic              u_req,
    input  logic              u_wr,
    input  logic [ADDR_W-1:0] u_addr,
    input  logic [DATA_W-1:0] u_wdata,
    output logic              u_gnt,
    output logic              u_rvalid,
    output logic [DATA_W-1:0] u_rdata,

    input  logic              flag_req,
    input  logic [DATA_W-1:0] flag_wdata,
    output logic              flag_ack,

    output logic              mem_rd_req,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rd_ready,
    input  logic [DATA_W-1:0] mem_rd_data,

    output logic              rd_err,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        RET  = 2'd3
    } state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t            state;
    logic              owner_u;     // 1 = user path owns the burst, 0 = host
    logic [7:0]        burst;       // consecutive grants given to owner
    logic              rd_u;        // outstanding read belongs to user path

    logic              pick_u;
    logic              owner_nxt;
    logic [7:0]        burst_nxt;
    logic              sel_wr;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(32'hDEAD_BEEF);

    logic [CNT_W-1:0] rd_cnt;
`else
    assign rd_err = 1'b0;
`endif

    assign dbg_state = state;

    // Owner/burst arbitration between host and user, plus next owner/burst.
    always_comb begin
        pick_u = u_req;
        if (h_req && u_req) begin
            pick_u = (burst < MAX_B) ? owner_u : ~owner_u;
        end

        owner_nxt = owner_u;
        burst_nxt = burst;
        if (pick_u == owner_u) begin
            burst_nxt = (burst >= MAX_B) ? MAX_B : burst + 8'd1;
        end else begin
            owner_nxt = pick_u;
            burst_nxt = 8'd1;
        end

        sel_wr    = pick_u ? u_wr    : h_wr;
        sel_addr  = pick_u ? u_addr  : h_addr;
        sel_wdata = pick_u ? u_wdata : h_wdata;
    end

    // Arbiter FSM with registered command, grant and read-return outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner_u    <= 1'b0;
            burst      <= 8'd0;
            rd_u       <= 1'b0;
            h_gnt      <= 1'b0;
            u_gnt      <= 1'b0;
            flag_ack   <= 1'b0;
            h_rvalid   <= 1'b0;
            u_rvalid   <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_en  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            h_rdata    <= '0;
            u_rdata    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            rd_cnt     <= '0;
            rd_err     <= 1'b0;
`endif
        end else begin
            // Pulse outputs default low; the state actions below raise them.
            h_gnt     <= 1'b0;
            u_gnt     <= 1'b0;
            flag_ack  <= 1'b0;
            h_rvalid  <= 1'b0;
            u_rvalid  <= 1'b0;
            mem_wr_en <= 1'b0;
`ifdef MEM_ARB_TIMEOUT_EN
            rd_err    <= 1'b0;
`endif

            case (state)
                IDLE: begin
                    if (flag_req) begin
                        // Flag writes win but leave owner/burst untouched.
                        state     <= WR;
                        mem_wr_en <= 1'b1;
                        flag_ack  <= 1'b1;
                        mem_addr  <= FLAG_ADDR;
                        mem_wdata <= flag_wdata;
                    end else if (h_req || u_req) begin
                        owner_u   <= owner_nxt;
                        burst     <= burst_nxt;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        h_gnt     <= ~pick_u;
                        u_gnt     <= pick_u;
                        if (sel_wr) begin
                            state     <= WR;
                            mem_wr_en <= 1'b1;
                        end else begin
                            state      <= RD;
                            mem_rd_req <= 1'b1;
                            rd_u       <= pick_u;
`ifdef MEM_ARB_TIMEOUT_EN
                            rd_cnt     <= '0;
`endif
                        end
                    end
                end

                WR: begin
                    state <= IDLE;
                end

                RD: begin
                    if (mem_rd_ready) begin
                        mem_rd_req <= 1'b0;
                        state      <= RET;
                        if (rd_u) begin
                            u_rdata  <= mem_rd_data;
                            u_rvalid <= 1'b1;
                        end else begin
                            h_rdata  <= mem_rd_data;
                            h_rvalid <= 1'b1;
                        end
                    end
`ifdef MEM_ARB_TIMEOUT_EN
                    else if (rd_cnt == CNT_LAST) begin
                        // Memory never answered: return a poison word.
                        mem_rd_req <= 1'b0;
                        state      <= RET;
                        rd_err     <= 1'b1;
                        if (rd_u) begin
                            u_rdata  <= ERR_WORD;
                            u_rvalid <= 1'b1;
                        end else begin
                            h_rdata  <= ERR_WORD;
                            h_rvalid <= 1'b1;
                        end
                    end else begin
                        rd_cnt <= rd_cnt + CNT_W'(1);
                    end
`endif
                end

                RET: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
